// File: rtl/hub75_scan_pkg.sv
// hub75_scan_pkg: panel geometry, word layout, counter widths and FSM
// encoding shared by the HUB75 scan driver and its gamma helper.
package hub75_scan_pkg;

  localparam int COLS         = 32;
  localparam int SCAN_ROWS    = 16;
  localparam int PLANES       = 4;
  localparam int BASE_CYCLES  = 8;
  localparam int BLANK_CYCLES = 2;

  localparam int COL_W   = $clog2(COLS);
  localparam int ROW_W   = $clog2(SCAN_ROWS);
  localparam int PLANE_W = $clog2(PLANES);
  localparam int ADDR_W  = ROW_W + COL_W;

  // Pixel-pair word: {bottom[47:24], top[23:0]}, each colour {B, G, R}.
  localparam int CHAN_W   = 8;
  localparam int PIXEL_W  = 24;
  localparam int WORD_W   = 2 * PIXEL_W;
  localparam int NUM_CHAN = WORD_W / CHAN_W;
  localparam int R_OFS    = 0;
  localparam int G_OFS    = 8;
  localparam int B_OFS    = 16;
  localparam int BOT_OFS  = 24;

  // One counter width serves both the SHIFT clock index (0..65) and the
  // longest display period (BASE_CYCLES << (PLANES-1)).
  localparam int SHIFT_CYCLES = 2 * COLS + 2;
  localparam int CNT_W        = $clog2(BASE_CYCLES << (PLANES - 1)) + 1;

  localparam logic [CNT_W-1:0] SHIFT_LAST   = CNT_W'(SHIFT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHIFT_ADDR_N = CNT_W'(2 * COLS);
  localparam logic [CNT_W-1:0] DISP_BASE    = CNT_W'(BASE_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [2:0]       PLANE_BIT0   = 3'(CHAN_W - PLANES);

  typedef enum logic [1:0] {
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY,
    ST_BLANK
  } scan_state_e;

endpackage

// File: rtl/hub75_gamma.sv
// hub75_gamma: approximate gamma 2.0 curve, out = (c*c) >> 8, purely combinational.
module hub75_gamma
  import hub75_scan_pkg::*;
(
  input  logic [CHAN_W-1:0] chan_in,
  output logic [CHAN_W-1:0] chan_out
);

  logic [2*CHAN_W-1:0] square;

  // Keep only the high byte of the square so full scale stays near full scale.
  always_comb begin
    square   = (2*CHAN_W)'(chan_in) * (2*CHAN_W)'(chan_in);
    chan_out = square[2*CHAN_W-1:CHAN_W];
  end

endmodule

// File: rtl/hub75_scan.sv
// hub75_scan: 1/16-scan HUB75 driver for a 32x32 panel using BCM bit planes.
// Define HUB75_SCAN_GAMMA_EN to square each sampled channel before plane selection.
module hub75_scan
  import hub75_scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [WORD_W-1:0] ram_data,
  output logic              r0,
  output logic              g0,
  output logic              b0,
  output logic              r1,
  output logic              g1,
  output logic              b1,
  output logic              sclk,
  output logic              latch,
  output logic              oe_n,
  output logic [ROW_W-1:0]  row_addr,
  output logic              frame_start
);

  scan_state_e              state_q, state_d;
  logic                     started_q, started_d;
  logic [CNT_W-1:0]         shift_t_q, shift_t_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [PLANE_W-1:0]       plane_q, plane_d;
  logic [ADDR_W-1:0]        ram_address_q, ram_address_d;
  logic [NUM_CHAN-1:0]      rgb_q, rgb_d;
  logic                     sclk_q, sclk_d;
  logic                     latch_q, latch_d;
  logic                     oe_n_q, oe_n_d;
  logic [ROW_W-1:0]         row_addr_q, row_addr_d;
  logic                     frame_start_q, frame_start_d;

  logic [NUM_CHAN-1:0][CHAN_W-1:0] chan_raw;
  logic [NUM_CHAN-1:0][CHAN_W-1:0] chan_val;
  logic [2:0]                      bit_idx;

  // Split the pixel pair into channels in word order: top R,G,B then bottom R,G,B.
  always_comb begin
    for (int i = 0; i < NUM_CHAN; i++) begin
      chan_raw[i] = ram_data[i*CHAN_W +: CHAN_W];
    end
  end

`ifdef HUB75_SCAN_GAMMA_EN
  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_gamma
    hub75_gamma u_gamma (
      .chan_in  (chan_raw[i]),
      .chan_out (chan_val[i])
    );
  end
`else
  assign chan_val = chan_raw;
`endif

  // Next-state and next-output logic; every output is the registered copy of its _d.
  always_comb begin
    state_d       = state_q;
    started_d     = started_q;
    shift_t_d     = shift_t_q;
    cnt_d         = cnt_q;
    row_d         = row_q;
    plane_d       = plane_q;
    ram_address_d = ram_address_q;
    rgb_d         = rgb_q;
    sclk_d        = sclk_q;
    latch_d       = 1'b0;
    oe_n_d        = oe_n_q;
    row_addr_d    = row_addr_q;
    frame_start_d = 1'b0;
    bit_idx       = PLANE_BIT0 + {1'b0, plane_q};

    if (!started_q) begin
      // The reset period stands in for the clock before SHIFT t=0.
      started_d     = 1'b1;
      state_d       = ST_SHIFT;
      shift_t_d     = '0;
      ram_address_d = {row_q, COL_W'(0)};
      frame_start_d = (row_q == '0) && (plane_q == '0);
      sclk_d        = 1'b0;
      oe_n_d        = 1'b1;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (shift_t_q == SHIFT_LAST) begin
            state_d    = ST_LATCH;
            latch_d    = 1'b1;
            sclk_d     = 1'b0;
            row_addr_d = row_q;
          end else begin
            shift_t_d = shift_t_q + 1'b1;
            if (shift_t_q[0]) begin
              for (int i = 0; i < NUM_CHAN; i++) begin
                rgb_d[i] = chan_val[i][bit_idx];
              end
              sclk_d = 1'b0;
            end else if (shift_t_q != '0) begin
              sclk_d = 1'b1;
            end
            if (shift_t_d < SHIFT_ADDR_N) begin
              ram_address_d = {row_q, shift_t_d[COL_W:1]};
            end
          end
        end
        ST_LATCH: begin
          state_d = ST_DISPLAY;
          oe_n_d  = 1'b0;
          cnt_d   = (DISP_BASE << plane_q) - 1'b1;
        end
        ST_DISPLAY: begin
          if (cnt_q == '0) begin
            state_d = ST_BLANK;
            oe_n_d  = 1'b1;
            cnt_d   = BLANK_LAST;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt_q == '0) begin
            if (plane_q == PLANE_W'(PLANES - 1)) begin
              plane_d = '0;
              row_d   = (row_q == ROW_W'(SCAN_ROWS - 1)) ? '0 : row_q + 1'b1;
            end else begin
              plane_d = plane_q + 1'b1;
            end
            state_d       = ST_SHIFT;
            shift_t_d     = '0;
            ram_address_d = {row_d, COL_W'(0)};
            frame_start_d = (row_d == '0) && (plane_d == '0);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_SHIFT;
        end
      endcase
    end
  end

  // State and output registers; reset returns the panel to dark and idle at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_SHIFT;
      started_q     <= 1'b0;
      shift_t_q     <= '0;
      cnt_q         <= '0;
      row_q         <= '0;
      plane_q       <= '0;
      ram_address_q <= '0;
      rgb_q         <= '0;
      sclk_q        <= 1'b0;
      latch_q       <= 1'b0;
      oe_n_q        <= 1'b1;
      row_addr_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      started_q     <= started_d;
      shift_t_q     <= shift_t_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      plane_q       <= plane_d;
      ram_address_q <= ram_address_d;
      rgb_q         <= rgb_d;
      sclk_q        <= sclk_d;
      latch_q       <= latch_d;
      oe_n_q        <= oe_n_d;
      row_addr_q    <= row_addr_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign ram_address = ram_address_q;
  assign r0          = rgb_q[R_OFS / CHAN_W];
  assign g0          = rgb_q[G_OFS / CHAN_W];
  assign b0          = rgb_q[B_OFS / CHAN_W];
  assign r1          = rgb_q[(BOT_OFS + R_OFS) / CHAN_W];
  assign g1          = rgb_q[(BOT_OFS + G_OFS) / CHAN_W];
  assign b1          = rgb_q[(BOT_OFS + B_OFS) / CHAN_W];
  assign sclk        = sclk_q;
  assign latch       = latch_q;
  assign oe_n        = oe_n_q;
  assign row_addr    = row_addr_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hub75_scan.sv
// tb_hub75_scan: directed self-checking bench for the HUB75 scan driver.
// Honours HUB75_SCAN_GAMMA_EN so the same bench covers both builds.
module tb_hub75_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [8:0]  ram_address;
  logic [47:0] ram_data;
  logic        r0, g0, b0, r1, g1, b1;
  logic        sclk, latch, oe_n, frame_start;
  logic [3:0]  row_addr;

  int          errors = 0;
  int          checks = 0;
  int          data_mode = 0;
  logic [47:0] const_word = '0;
  logic [3:0]  exp_row_addr = '0;

  hub75_scan dut (
    .clk         (clk),
    .rst         (rst),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .r0          (r0),
    .g0          (g0),
    .b0          (b0),
    .r1          (r1),
    .g1          (g1),
    .b1          (b1),
    .sclk        (sclk),
    .latch       (latch),
    .oe_n        (oe_n),
    .row_addr    (row_addr),
    .frame_start (frame_start)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  // Pixel RAM model: returns the word for the address seen on the previous clock.
  always @(posedge clk) begin
    if (data_mode == 0) ram_data <= const_word;
    else ram_data <= {8'h00, ~ram_address[7:0], 8'h00, 16'h0000, ram_address[7:0]};
  end

  // Hard stop in case the bench itself loses its way.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish, want finish before 5 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] chan_map(input logic [7:0] c);
`ifdef HUB75_SCAN_GAMMA_EN
    logic [15:0] sq;
    sq = 16'(c) * 16'(c);
    return sq[15:8];
`else
    return c;
`endif
  endfunction

  // Expected {b1,g1,r1,b0,g0,r0} for the address-pattern RAM contents.
  function automatic logic [5:0] pattern_rgb(input logic [8:0] addr, input int plane);
    logic [7:0] top_r;
    logic [7:0] bot_g;
    top_r = chan_map(addr[7:0]);
    bot_g = chan_map(~addr[7:0]);
    return {1'b0, bot_g[4+plane], 1'b0, 1'b0, 1'b0, top_r[4+plane]};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_row_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Walks one SHIFT/LATCH/DISPLAY/BLANK window; stop_t >= 0 returns after that SHIFT clock.
  task automatic check_window(input int row, input int plane, input logic [5:0] const_rgb,
                              input int stop_t);
    logic [3:0] exp_ctrl;
    logic [8:0] exp_addr;
    logic [5:0] exp_rgb;
    int         n;
    for (int t = 0; t < 66; t++) begin
      @(negedge clk);
      exp_ctrl = {(t >= 3 && t % 2 == 1), 1'b0, 1'b1, (t == 0 && row == 0 && plane == 0)};
      checks++;
      if ({sclk, latch, oe_n, frame_start} !== exp_ctrl) begin
        errors++;
        $display("[TB] FAIL shift_ctrl r%0d p%0d t%0d: got %b want %b (sclk,latch,oe_n,fs)",
                 row, plane, t, {sclk, latch, oe_n, frame_start}, exp_ctrl);
      end
      if (t < 64) begin
        exp_addr = 9'(row * 32 + t / 2);
        checks++;
        if (ram_address !== exp_addr) begin
          errors++;
          $display("[TB] FAIL address r%0d p%0d t%0d: got %0d want %0d",
                   row, plane, t, ram_address, exp_addr);
        end
      end
      checks++;
      if (row_addr !== exp_row_addr) begin
        errors++;
        $display("[TB] FAIL row_hold r%0d p%0d t%0d: got %0d want %0d",
                 row, plane, t, row_addr, exp_row_addr);
      end
      if (t >= 2) begin
        exp_rgb = (data_mode == 0) ? const_rgb : pattern_rgb(9'(row * 32 + (t - 2) / 2), plane);
        checks++;
        if ({b1, g1, r1, b0, g0, r0} !== exp_rgb) begin
          errors++;
          $display("[TB] FAIL rgb r%0d p%0d t%0d: got %b want %b (b1g1r1b0g0r0)",
                   row, plane, t, {b1, g1, r1, b0, g0, r0}, exp_rgb);
        end
      end
      if (t == stop_t) return;
    end
    @(negedge clk);
    exp_row_addr = 4'(row);
    checks++;
    if ({sclk, latch, oe_n, frame_start, row_addr} !== {4'b0110, exp_row_addr}) begin
      errors++;
      $display("[TB] FAIL latch r%0d p%0d: got %b want %b", row, plane,
               {sclk, latch, oe_n, frame_start, row_addr}, {4'b0110, exp_row_addr});
    end
    n = 8 << plane;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if ({sclk, latch, oe_n, frame_start, row_addr} !== {4'b0000, exp_row_addr}) begin
        errors++;
        $display("[TB] FAIL display r%0d p%0d i%0d: got %b want %b", row, plane, i,
                 {sclk, latch, oe_n, frame_start, row_addr}, {4'b0000, exp_row_addr});
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({sclk, latch, oe_n, frame_start, row_addr} !== {4'b0010, exp_row_addr}) begin
        errors++;
        $display("[TB] FAIL blank r%0d p%0d i%0d: got %b want %b", row, plane, i,
                 {sclk, latch, oe_n, frame_start, row_addr}, {4'b0010, exp_row_addr});
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (ram_address !== 9'd0) begin
      errors++;
      $display("[TB] FAIL %s_addr: got %0d want 0", tag, ram_address);
    end
    checks++;
    if ({b1, g1, r1, b0, g0, r0} !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL %s_rgb: got %b want 000000", tag, {b1, g1, r1, b0, g0, r0});
    end
    checks++;
    if ({sclk, latch, oe_n, frame_start} !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL %s_ctrl: got %b want 0010", tag, {sclk, latch, oe_n, frame_start});
    end
    checks++;
    if (row_addr !== 4'd0) begin
      errors++;
      $display("[TB] FAIL %s_row: got %0d want 0", tag, row_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
  endtask

  // Full frame of row/plane windows, then the next frame_start with address 0.
  task automatic test_address_sequence();
    data_mode = 1;
    apply_reset();
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < 4; p++) check_window(r, p, 6'b0, -1);
    end
    check_window(0, 0, 6'b0, 5);
  endtask

  task automatic test_bit_mapping();
    logic [5:0] exp_rgb;
    data_mode = 0;
    const_word = {24'h0000FF, 24'h800000};
    apply_reset();
    for (int p = 0; p < 4; p++) begin
`ifdef HUB75_SCAN_GAMMA_EN
      exp_rgb = (p == 2) ? 6'b001100 : 6'b001000;
`else
      exp_rgb = (p == 3) ? 6'b001100 : 6'b001000;
`endif
      check_window(0, p, exp_rgb, -1);
    end
  endtask

  task automatic test_gamma();
    logic [5:0] exp_rgb;
    data_mode = 0;
    const_word = {24'h000000, 24'h000080};
    apply_reset();
    for (int p = 0; p < 4; p++) begin
`ifdef HUB75_SCAN_GAMMA_EN
      exp_rgb = (p == 2) ? 6'b000001 : 6'b000000;
`else
      exp_rgb = (p == 3) ? 6'b000001 : 6'b000000;
`endif
      check_window(0, p, exp_rgb, -1);
    end
  endtask

  task automatic test_reset_mid_shift();
    data_mode = 1;
    apply_reset();
    for (int r = 0; r < 5; r++) begin
      for (int p = 0; p < 4; p++) check_window(r, p, 6'b0, -1);
    end
    check_window(5, 0, 6'b0, 20);
    rst = 1'b0;
    #1;
    check_reset_values("midreset");
    exp_row_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check_window(0, 0, 6'b0, -1);
    check_window(0, 1, 6'b0, -1);
  endtask

  initial begin
    test_reset();
    test_address_sequence();
    test_bit_mapping();
    test_gamma();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
